// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helper functions for the FIFO pointer controller
//
// Contents:
//   DEFAULT_DEPTH      default number of storage words
//   DEFAULT_AF_MARGIN  almost_full asserts this many words below full by default
//   DEFAULT_AE_LEVEL   default almost_empty threshold
//   clog2()            ceiling log2, used to size the pointers
//   next_ptr()         pointer advance with wrap at an arbitrary depth
package fifo_pkg;

    localparam int unsigned DEFAULT_DEPTH     = 128;
    localparam int unsigned DEFAULT_AF_MARGIN = 2;
    localparam int unsigned DEFAULT_AE_LEVEL  = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Wraps at depth-1 rather than at a power of two, so a pointer never
    // addresses a word beyond the end of the storage bank.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - parametrised enable-gated one-hot decoder
//
// Ports:
//   idx_i     N-bit word index
//   en_i      decode enable; output is all-zero when low
//   onehot_o  DEPTH-wide one-hot select, at most one bit set
module onehot_dec #(
    parameter int unsigned N     = 7,
    parameter int unsigned DEPTH = 128
) (
    input  logic [N-1:0]     idx_i,
    input  logic             en_i,
    output logic [DEPTH-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            onehot_o[i] = en_i & (idx_i == N'(i));
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - pointer, word-select and flag controller for register-file FIFOs
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   wr_en         push request
//   rd_en         pop request
//   clr           synchronous flush of pointers, count and error flags
//   wr_sel        one-hot word write enable into the storage bank
//   rd_addr       index of the head word for the storage read mux
//   full, empty   occupancy at DEPTH / at zero
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         current occupancy, 0..DEPTH
//   ovf, udf      sticky push-while-full / pop-while-empty flags
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned AW       = clog2(DEPTH),
    parameter int unsigned AF_LEVEL = DEPTH - DEFAULT_AF_MARGIN,
    parameter int unsigned AE_LEVEL = DEFAULT_AE_LEVEL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             clr,
    output logic [DEPTH-1:0] wr_sel,
    output logic [AW-1:0]    rd_addr,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             ovf,
    output logic             udf
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wr_acc, rd_acc;

    // Flags come only from the registered count, so full/empty reflect the
    // state before this cycle's push or pop.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (32'(count_q) >= AF_LEVEL);
    assign almost_empty = (32'(count_q) <= AE_LEVEL);

    // rst gates acceptance combinationally so wr_sel drops the moment reset
    // asserts, not at the next edge; clr suppresses writes in its own cycle.
    assign wr_acc = wr_en & ~full  & ~clr & ~rst;
    assign rd_acc = rd_en & ~empty & ~clr & ~rst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = AW'(next_ptr(32'(wr_ptr_q), DEPTH));
            end
            if (rd_acc) begin
                rd_ptr_d = AW'(next_ptr(32'(rd_ptr_q), DEPTH));
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (wr_en & full);
            udf_d = udf_q | (rd_en & empty);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    onehot_dec #(
        .N     (AW),
        .DEPTH (DEPTH)
    ) u_wr_dec (
        .idx_i    (wr_ptr_q),
        .en_i     (wr_acc),
        .onehot_o (wr_sel)
    );

    assign rd_addr = rd_ptr_q;
    assign count   = count_q;
    assign ovf     = ovf_q;
    assign udf     = udf_q;

endmodule
